// File: rtl/digital_clock_hms.sv
`default_nettype none
// ============================================================================
//  Module   : digital_clock_hms
//  Purpose  : 24-hour BCD hh:mm:ss time-of-day counter. Samples the 1 Hz
//             divider output as data on the system clock, advances one second
//             per rising edge, and supports minute/hour setting from debounced
//             buttons. Optional alarm comparator enabled by DIGCLK_ALARM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module digital_clock_hms #(
  parameter int RST_HOUR = 0,
  parameter int RST_MIN  = 0,
  parameter int RST_SEC  = 0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       run,
  input  logic       set_min,
  input  logic       set_hour,
`ifdef DIGCLK_ALARM_EN
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  output logic       alarm_out,
`endif
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_pulse,
  output logic       day_pulse
);

  // Reset time converted from binary parameters to BCD digits
  localparam logic [1:0] c_rst_ht = 2'(RST_HOUR / 10);
  localparam logic [3:0] c_rst_ho = 4'(RST_HOUR % 10);
  localparam logic [2:0] c_rst_mt = 3'(RST_MIN / 10);
  localparam logic [3:0] c_rst_mo = 4'(RST_MIN % 10);
  localparam logic [2:0] c_rst_st = 3'(RST_SEC / 10);
  localparam logic [3:0] c_rst_so = 4'(RST_SEC % 10);

  // BCD increment modulo 60; MSB of the result flags the 59 -> 00 wrap
  function automatic logic [7:0] inc_m60(input logic [2:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones != 4'd9)      r = {1'b0, tens, ones + 4'd1};
    else if (tens != 3'd5) r = {1'b0, tens + 3'd1, 4'd0};
    else                   r = {1'b1, 3'd0, 4'd0};
    return r;
  endfunction

  // BCD increment modulo 24; MSB of the result flags the 23 -> 00 wrap
  function automatic logic [6:0] inc_h24(input logic [1:0] tens, input logic [3:0] ones);
    logic [6:0] r;
    if (tens == 2'd2 && ones == 4'd3) r = {1'b1, 2'd0, 4'd0};
    else if (ones == 4'd9)            r = {1'b0, tens + 2'd1, 4'd0};
    else                              r = {1'b0, tens, ones + 4'd1};
    return r;
  endfunction

  logic tick_s1_q, tick_s2_q, tick_prev_q;
  logic min_s1_q, min_s2_q, min_prev_q;
  logic hour_s1_q, hour_s2_q, hour_prev_q;

  logic [1:0] hour_tens_q, hour_tens_d;
  logic [3:0] hour_ones_q, hour_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       day_pulse_q, day_pulse_d;

  logic       tick_ev, min_ev, hour_ev, apply_tick;
  logic [7:0] sec_inc, min_inc;
  logic [6:0] hr_inc;

  // Input synchronizers and previous-value registers; tick path resets high
  // because the divider holds its output high during reset
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      tick_s1_q   <= 1'b1;
      tick_s2_q   <= 1'b1;
      tick_prev_q <= 1'b1;
      min_s1_q    <= 1'b0;
      min_s2_q    <= 1'b0;
      min_prev_q  <= 1'b0;
      hour_s1_q   <= 1'b0;
      hour_s2_q   <= 1'b0;
      hour_prev_q <= 1'b0;
    end else begin
      tick_s1_q   <= tick_in;
      tick_s2_q   <= tick_s1_q;
      tick_prev_q <= tick_s2_q;
      min_s1_q    <= set_min;
      min_s2_q    <= min_s1_q;
      min_prev_q  <= min_s2_q;
      hour_s1_q   <= set_hour;
      hour_s2_q   <= hour_s1_q;
      hour_prev_q <= hour_s2_q;
    end
  end

  assign tick_ev    = tick_s2_q & ~tick_prev_q;
  assign min_ev     = min_s2_q & ~min_prev_q;
  assign hour_ev    = hour_s2_q & ~hour_prev_q;
  // A set event always wins; a coincident tick is dropped
  assign apply_tick = tick_ev & run & ~min_ev & ~hour_ev;

  assign sec_inc = inc_m60(sec_tens_q, sec_ones_q);
  assign min_inc = inc_m60(min_tens_q, min_ones_q);
  assign hr_inc  = inc_h24(hour_tens_q, hour_ones_q);

  // Next-time computation: carry chain on tick, independent setting on buttons
  always_comb begin
    hour_tens_d = hour_tens_q;
    hour_ones_d = hour_ones_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    if (apply_tick) begin
      sec_pulse_d              = 1'b1;
      {sec_tens_d, sec_ones_d} = sec_inc[6:0];
      if (sec_inc[7]) begin
        {min_tens_d, min_ones_d} = min_inc[6:0];
        if (min_inc[7]) begin
          {hour_tens_d, hour_ones_d} = hr_inc[5:0];
          day_pulse_d                = hr_inc[6];
        end
      end
    end
    if (min_ev) begin
      {min_tens_d, min_ones_d} = min_inc[6:0];
      sec_tens_d               = 3'd0;
      sec_ones_d               = 4'd0;
    end
    if (hour_ev) begin
      {hour_tens_d, hour_ones_d} = hr_inc[5:0];
    end
  end

  // Time digits and strobes
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      hour_tens_q <= c_rst_ht;
      hour_ones_q <= c_rst_ho;
      min_tens_q  <= c_rst_mt;
      min_ones_q  <= c_rst_mo;
      sec_tens_q  <= c_rst_st;
      sec_ones_q  <= c_rst_so;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      hour_tens_q <= hour_tens_d;
      hour_ones_q <= hour_ones_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign hour_tens = hour_tens_q;
  assign hour_ones = hour_ones_q;
  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;

`ifdef DIGCLK_ALARM_EN
  logic alarm_out_q;

  // Alarm compare against the registered time, one cycle behind the digits
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      alarm_out_q <= 1'b0;
    end else begin
      alarm_out_q <= alarm_arm
                     && ({2'b00, hour_tens_q, hour_ones_q} == alarm_hh)
                     && ({1'b0, min_tens_q, min_ones_q} == alarm_mm);
    end
  end

  assign alarm_out = alarm_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_digital_clock_hms.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digital_clock_hms
//  Purpose  : Directed self-checking bench for digital_clock_hms. Several
//             instances with different reset times share one stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_digital_clock_hms;

  localparam int NI   = 7;
  localparam int I0   = 0;  // 00:00:00
  localparam int I58  = 1;  // 00:00:58
  localparam int IDAY = 2;  // 23:59:59
  localparam int ISET = 3;  // 10:59:30
  localparam int IH23 = 4;  // 23:15:07
  localparam int ISIM = 5;  // 05:12:40
  localparam int IAL  = 6;  // 07:29:59

  localparam int P_H [NI] = '{0, 0, 23, 10, 23, 5, 7};
  localparam int P_M [NI] = '{0, 0, 59, 59, 15, 12, 29};
  localparam int P_S [NI] = '{0, 58, 59, 30, 7, 40, 59};

  logic clk_in = 1'b0;
  logic rst, tick_in, run, set_min, set_hour;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_arm;

  logic [1:0] ht [NI];
  logic [3:0] ho [NI];
  logic [2:0] mt [NI];
  logic [3:0] mo [NI];
  logic [2:0] st [NI];
  logic [3:0] so [NI];
  logic       sp [NI];
  logic       dp [NI];
  logic       al [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    digital_clock_hms #(
      .RST_HOUR(P_H[g]),
      .RST_MIN (P_M[g]),
      .RST_SEC (P_S[g])
    ) u_dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .tick_in  (tick_in),
      .run      (run),
      .set_min  (set_min),
      .set_hour (set_hour),
`ifdef DIGCLK_ALARM_EN
      .alarm_hh (alarm_hh),
      .alarm_mm (alarm_mm),
      .alarm_arm(alarm_arm),
      .alarm_out(al[g]),
`endif
      .hour_tens(ht[g]),
      .hour_ones(ho[g]),
      .min_tens (mt[g]),
      .min_ones (mo[g]),
      .sec_tens (st[g]),
      .sec_ones (so[g]),
      .sec_pulse(sp[g]),
      .day_pulse(dp[g])
    );
`ifndef DIGCLK_ALARM_EN
    assign al[g] = 1'b0;
`endif
  end

  // Time of instance i packed as BCD hex hhmmss
  function automatic logic [23:0] tm(input int i);
    return {2'b00, ht[i], ho[i], 1'b0, mt[i], mo[i], 1'b0, st[i], so[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    tick_in = 1'b1;
    rst     = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  // Raise tick_in; returns just after the update edge (sampling edge + 2)
  task automatic tick_pulse();
    tick_in = 1'b1;
    repeat (3) step();
  endtask

  task automatic tick_low();
    tick_in = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b0; tick_in = 1'b1; run = 1'b1; set_min = 1'b0; set_hour = 1'b0;
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 1'b1;

    // Reset state and quiet release with tick_in held high
    do_reset();
    check("rst_time0", {8'h0, tm(I0)}, 32'h000000);
    check("rst_time58", {8'h0, tm(I58)}, 32'h000058);
    check("rst_timeday", {8'h0, tm(IDAY)}, 32'h235959);
    for (int c = 0; c < 10; c++) begin
      check("rst_no_sec_pulse", {31'h0, sp[I0]}, 32'h0);
      step();
    end
    check("rst_no_day_pulse", {31'h0, dp[IDAY]}, 32'h0);

    // Seconds advance with exact 2-cycle latency, plus day rollover
    tick_low();
    tick_in = 1'b1;
    step();  // sampling edge k
    check("lat_k", {8'h0, tm(I58)}, 32'h000058);
    step();  // k+1
    check("lat_k1", {8'h0, tm(I58)}, 32'h000058);
    check("lat_k1_sp", {31'h0, sp[I58]}, 32'h0);
    step();  // k+2
    check("tick1_time", {8'h0, tm(I58)}, 32'h000059);
    check("tick1_sp", {31'h0, sp[I58]}, 32'h1);
    check("tick1_dp_none", {31'h0, dp[I58]}, 32'h0);
    check("day_time", {8'h0, tm(IDAY)}, 32'h000000);
    check("day_dp", {31'h0, dp[IDAY]}, 32'h1);
    step();
    check("tick1_sp_end", {31'h0, sp[I58]}, 32'h0);
    check("day_dp_end", {31'h0, dp[IDAY]}, 32'h0);
    tick_low();
    tick_pulse();
    check("tick2_time", {8'h0, tm(I58)}, 32'h000100);
    check("tick2_sp", {31'h0, sp[I58]}, 32'h1);
    step();
    check("tick2_sp_end", {31'h0, sp[I58]}, 32'h0);

    // Minute and hour setting
    do_reset();
    set_min = 1'b1;
    step(); step();
    check("setmin_k1", {8'h0, tm(ISET)}, 32'h105930);
    step();
    check("setmin_time", {8'h0, tm(ISET)}, 32'h100000);
    check("setmin_h23", {8'h0, tm(IH23)}, 32'h231600);
    check("setmin_no_sp", {31'h0, sp[ISET]}, 32'h0);
    set_min = 1'b0;
    repeat (3) step();
    set_hour = 1'b1;
    repeat (3) step();
    check("sethour_wrap", {8'h0, tm(IH23)}, 32'h001600);
    check("sethour_no_dp", {31'h0, dp[IH23]}, 32'h0);
    check("sethour_set", {8'h0, tm(ISET)}, 32'h110000);
    step();
    check("sethour_no_dp2", {31'h0, dp[IH23]}, 32'h0);
    set_hour = 1'b0;
    repeat (3) step();

    // Both buttons in the same cycle
    do_reset();
    set_min = 1'b1; set_hour = 1'b1;
    repeat (3) step();
    check("both_set", {8'h0, tm(IH23)}, 32'h001600);
    set_min = 1'b0; set_hour = 1'b0;
    repeat (3) step();

    // Set event beats a coincident tick
    do_reset();
    tick_low();
    tick_in = 1'b1; set_min = 1'b1;
    repeat (3) step();
    check("sim_time", {8'h0, tm(ISIM)}, 32'h051300);
    check("sim_no_sp", {31'h0, sp[ISIM]}, 32'h0);
    step();
    check("sim_no_sp2", {31'h0, sp[ISIM]}, 32'h0);
    check("sim_hold", {8'h0, tm(ISIM)}, 32'h051300);
    set_min = 1'b0;
    tick_low();

    // Frozen time while run=0
    run = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick_pulse();
      check("run0_time", {8'h0, tm(ISIM)}, 32'h051300);
      check("run0_no_sp", {31'h0, sp[ISIM]}, 32'h0);
      tick_low();
    end
    run = 1'b1;

`ifdef DIGCLK_ALARM_EN
    // Alarm window for 07:30 while armed
    do_reset();
    check("al_rst", {31'h0, al[IAL]}, 32'h0);
    tick_low();
    tick_pulse();
    check("al_time0730", {8'h0, tm(IAL)}, 32'h073000);
    check("al_lat", {31'h0, al[IAL]}, 32'h0);
    step();
    check("al_rise", {31'h0, al[IAL]}, 32'h1);
    tick_low();
    for (int t = 0; t < 59; t++) begin
      tick_pulse();
      tick_low();
    end
    check("al_time3059", {8'h0, tm(IAL)}, 32'h073059);
    check("al_hold", {31'h0, al[IAL]}, 32'h1);
    tick_pulse();
    check("al_time0731", {8'h0, tm(IAL)}, 32'h073100);
    check("al_fall_lat", {31'h0, al[IAL]}, 32'h1);
    step();
    check("al_fall", {31'h0, al[IAL]}, 32'h0);
    tick_low();

    // Disarmed: never asserts at the matching minute
    alarm_arm = 1'b0;
    do_reset();
    tick_low();
    tick_pulse();
    for (int c = 0; c < 4; c++) begin
      step();
      check("al_disarmed", {31'h0, al[IAL]}, 32'h0);
    end
    tick_low();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
